// File: rtl/wb_regfile.sv
// Writeback stage and register file for the 16-bit core.
// Selects the writeback value from MEM/WB, commits it to the register file,
// and serves two combinational read ports with same-cycle write bypass.
// Also records the last committed write for debug and trace.

// One combinational read port. Priority: hard-wired zero register, then
// bypass of the in-flight commit, then the stored array value.
module wb_rdport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic                                 wb_active,
    input  logic [ADDR_W-1:0]                    wb_rd,
    input  logic [DATA_W-1:0]                    wb_data,
    output logic [DATA_W-1:0]                    rdata
);
    // Read-port priority mux
    always_comb begin
        rdata = regs[addr];
        if ((ZERO_REG != 0) && (addr == '0))
            rdata = '0;
        else if (wb_active && (addr == wb_rd))
            rdata = wb_data;
    end
endmodule

module wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              ResetN,
    input  logic              WBRegWrite,
    input  logic [1:0]        WBRegStore,
    input  logic [DATA_W-1:0] WBPCP2,
    input  logic [DATA_W-1:0] WBALUResult,
    input  logic [DATA_W-1:0] WBStoreMem,
    input  logic [ADDR_W-1:0] WBRd,
    input  logic [ADDR_W-1:0] RAddr1,
    input  logic [ADDR_W-1:0] RAddr2,
    output logic [DATA_W-1:0] RData1,
    output logic [DATA_W-1:0] RData2,
    output logic [DATA_W-1:0] WBData,
    output logic              WBActive,
    output logic [ADDR_W-1:0] LastRd,
    output logic [DATA_W-1:0] LastData,
    output logic [15:0]       WriteCount
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int NUM_PORTS = 2;

    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] raddr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;
    logic                             zero_hit;

    // Writeback source select; 11 selects nothing and yields zero
    always_comb begin
        case (WBRegStore)
            2'b00:   WBData = WBALUResult;
            2'b01:   WBData = WBStoreMem;
            2'b10:   WBData = WBPCP2;
            default: WBData = '0;
        endcase
    end

    // Writes to a hard-wired zero register are dropped entirely, so they
    // neither bypass nor count as commits.
    assign zero_hit = (ZERO_REG != 0) && (WBRd == '0);
    assign WBActive = ResetN & WBRegWrite & (WBRegStore != 2'b11) & ~zero_hit;

    // Commit to the array and update the trace record; reset wins over a same-edge commit
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            regs       <= '0;
            LastRd     <= '0;
            LastData   <= '0;
            WriteCount <= '0;
        end else if (WBActive) begin
            regs[WBRd] <= WBData;
            LastRd     <= WBRd;
            LastData   <= WBData;
            WriteCount <= WriteCount + 16'd1;
        end
    end

    assign raddr[0] = RAddr1;
    assign raddr[1] = RAddr2;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
        wb_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .addr      (raddr[g]),
            .regs      (regs),
            .wb_active (WBActive),
            .wb_rd     (WBRd),
            .wb_data   (WBData),
            .rdata     (rdata[g])
        );
    end

    assign RData1 = rdata[0];
    assign RData2 = rdata[1];
endmodule
